vend_multi_product_ctrl: RTL and testbench
==========================================

# vend_multi_product_ctrl

Parametrised vending controller: accumulates coins into a W-bit running total, keeps a programmable price table for N_PROD products, dispenses on a funded selection and returns change through a valid/ack handshake. Combines state machine and datapath in one block. Sits between the coin acceptor/keypad front end and the dispenser/change-hopper drivers.

## Interface
- W, 8: width of coin values, prices, total and change
- N_PROD, 4: number of products; selector width SW = max(1, clog2(N_PROD))
- PRICE_RST, 25: reset value of every price entry
- STOCK_W, 4: stock counter width (used only with VEND_STOCK_EN)
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous active-low reset
- coin_valid  in  1  one-cycle strobe, coin present
- coin_val  in  W  value of the strobed coin
- sel_valid  in  1  one-cycle strobe, product selected
- sel_idx  in  SW  selected product
- cancel  in  1  one-cycle strobe, refund request
- price_we  in  1  price table write strobe
- price_idx  in  SW  price entry to write
- price_data  in  W  new price
- stock_ld  in  1  stock load strobe
- stock_idx  in  SW  stock entry to load
- stock_data  in  STOCK_W  new stock count
- change_ack  in  1  hopper has taken change_amt
- total  out  W  current credit
- busy  out  1  high in DISPENSE or CHANGE
- disp  out  1  one-cycle dispense pulse
- disp_idx  out  SW  product being dispensed, valid with disp
- change_valid  out  1  change_amt valid, held until ack
- change_amt  out  W  amount to return
- coin_reject  out  1  one-cycle pulse, coin refused
- short_funds  out  1  one-cycle pulse, selection underfunded
- sold_out  out  1  one-cycle pulse, selection has zero stock

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE. Reset: IDLE, total=0, change_amt=0, disp_idx=0, all pulses and change_valid 0, prices=PRICE_RST, stock=0.
- IDLE/COLLECT coin: total += coin_val and go to COLLECT, unless the sum overflows W bits -> coin_reject, total unchanged.
- IDLE/COLLECT sel (product in stock): if total >= price[sel_idx] -> latch disp_idx, change_amt = total - price, total=0, go to DISPENSE. Otherwise short_funds, no state change. Price 0 is a free vend even from IDLE with total 0.
- COLLECT cancel: change_amt=total, total=0, go to CHANGE. Cancel in IDLE is ignored.
- Priority in the same cycle: cancel > sel > coin. The losing coin is coin_reject; the losing sel is dropped silently.
- DISPENSE (exactly one cycle): disp=1. Next state is CHANGE if change_amt != 0, else IDLE.
- CHANGE: change_valid=1 and change_amt stable until change_ack is sampled high. Then go to IDLE, change_valid=0, change_amt=0. change_ack outside CHANGE is ignored.
- Coins in DISPENSE/CHANGE -> coin_reject. Sel/cancel in these states are ignored.
- price_we: applied only in IDLE, ignored elsewhere. An out-of-range idx (>= N_PROD) is ignored for price_we, stock_ld and sel (sel raises short_funds).

## Timing
- All outputs are registered. A strobe sampled at edge k takes effect at edge k; its outputs are visible in the following cycle.
- Sel at edge k -> disp high cycle k+1 -> change_valid high from cycle k+2 at the earliest.
- A handshake completes at the edge where change_valid and change_ack are both high. A new coin is accepted from the next cycle.
- Reset mid-CHANGE drops the pending change; prices return to PRICE_RST.

## Configuration
- VEND_STOCK_EN defined: per-product STOCK_W-bit counters, loaded by stock_ld in any state.
  - A selection with stock 0 -> sold_out, no state change, checked before funds.
  - Stock decrements on the disp cycle and never wraps below 0.
  - If stock_ld and a decrement hit the same entry, the load wins.
- Not defined: no counters; stock_ld, stock_idx and stock_data ignored; sold_out tied 0; every product always available.

## Structure
- Package vend_pkg: state encoding (IDLE=0, COLLECT=1, DISPENSE=2, CHANGE=3) and the SW derivation function.
- One sub-module, vend_price_table: N_PROD x W register file with write port, async read, async active-low reset to PRICE_RST.

## Test plan
- Coins 10, 10, 10, then sel 0 (price 25) -> disp cycle +1, disp_idx=0; change_valid with change_amt=5 until ack; then IDLE, total 0.
- Total 20, sel 1 (price 25) -> short_funds pulse, total stays 20; cancel -> change_amt=20, ack -> IDLE.
- Total 250 (W=8), coin 10 -> coin_reject, total 250; coin and sel same cycle with total 250, price 250 -> disp, coin_reject, change 0 -> IDLE.
- price_we idx 2 = 0 in IDLE, sel 2 with total 0 -> free disp, no change phase; price_we during CHANGE -> ignored.
- VEND_STOCK_EN: stock_ld idx 3 = 1, two funded sels of 3 -> first disp, second sold_out with credit kept.
- nrst low while change_valid held -> all outputs 0, total 0, prices back to 25 asynchronously.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and selector-width helpers for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_e;

    // Selector width: at least one bit even for a single-product machine.
    function automatic int vend_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when a product index addresses a real table entry.
    function automatic logic vend_idx_ok(input int idx, input int n);
        return idx < n;
    endfunction

endpackage

// File: rtl/vend_price_table.sv
// rtl/vend_price_table.sv - N_PROD x W price register file, one write port, async read
module vend_price_table
    import vend_pkg::*;
#(
    parameter  int W         = 8,
    parameter  int N_PROD    = 4,
    parameter  int PRICE_RST = 25,
    localparam int SW        = vend_sel_w(N_PROD)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          we,
    input  logic [SW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic [SW-1:0] rd_idx,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_q [N_PROD];
    logic [W-1:0] mem_d [N_PROD];

    // Next table contents: a single in-range write per cycle.
    always_comb begin
        mem_d = mem_q;
        if (we && vend_idx_ok(int'(wr_idx), N_PROD)) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    // Table storage; every entry returns to the default price on reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < N_PROD; i++) begin
                mem_q[i] <= W'(PRICE_RST);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Out-of-range reads return zero; callers reject those indices anyway.
    always_comb begin
        rd_data = '0;
        if (vend_idx_ok(int'(rd_idx), N_PROD)) begin
            rd_data = mem_q[rd_idx];
        end
    end

endmodule

// File: rtl/vend_multi_product_ctrl.sv
// rtl/vend_multi_product_ctrl.sv - multi-product vending controller; VEND_STOCK_EN adds per-product stock counters
module vend_multi_product_ctrl
    import vend_pkg::*;
#(
    parameter  int W         = 8,
    parameter  int N_PROD    = 4,
    parameter  int PRICE_RST = 25,
    parameter  int STOCK_W   = 4,
    localparam int SW        = vend_sel_w(N_PROD)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               coin_valid,
    input  logic [W-1:0]       coin_val,
    input  logic               sel_valid,
    input  logic [SW-1:0]      sel_idx,
    input  logic               cancel,
    input  logic               price_we,
    input  logic [SW-1:0]      price_idx,
    input  logic [W-1:0]       price_data,
    input  logic               stock_ld,
    input  logic [SW-1:0]      stock_idx,
    input  logic [STOCK_W-1:0] stock_data,
    input  logic               change_ack,
    output logic [W-1:0]       total,
    output logic               busy,
    output logic               disp,
    output logic [SW-1:0]      disp_idx,
    output logic               change_valid,
    output logic [W-1:0]       change_amt,
    output logic               coin_reject,
    output logic               short_funds,
    output logic               sold_out
);

    vend_state_e   state_q, state_d;
    logic [W-1:0]  total_q, total_d;
    logic [W-1:0]  change_amt_q, change_amt_d;
    logic [SW-1:0] disp_idx_q, disp_idx_d;
    logic          disp_q, disp_d;
    logic          busy_q, busy_d;
    logic          change_valid_q, change_valid_d;
    logic          coin_reject_q, coin_reject_d;
    logic          short_funds_q, short_funds_d;

    logic [W-1:0]  price_sel;
    logic [W:0]    coin_sum;
    logic          coin_ovf;
    logic          sel_ok;

    // Prices can only change while the machine is idle.
    vend_price_table #(
        .W         (W),
        .N_PROD    (N_PROD),
        .PRICE_RST (PRICE_RST)
    ) u_price_table (
        .clk     (clk),
        .nrst    (nrst),
        .we      (price_we && (state_q == IDLE)),
        .wr_idx  (price_idx),
        .wr_data (price_data),
        .rd_idx  (sel_idx),
        .rd_data (price_sel)
    );

    assign coin_sum = {1'b0, total_q} + {1'b0, coin_val};
    assign coin_ovf = coin_sum[W];
    assign sel_ok   = vend_idx_ok(int'(sel_idx), N_PROD);

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_q [N_PROD];
    logic [STOCK_W-1:0] stock_d [N_PROD];
    logic               sold_out_q, sold_out_d;

    // Stock bookkeeping: decrement on the dispense cycle, a load to the same entry overrides it.
    always_comb begin
        stock_d = stock_q;
        if ((state_q == DISPENSE) && (stock_q[disp_idx_q] != '0)) begin
            stock_d[disp_idx_q] = stock_q[disp_idx_q] - STOCK_W'(1);
        end
        if (stock_ld && vend_idx_ok(int'(stock_idx), N_PROD)) begin
            stock_d[stock_idx] = stock_data;
        end
    end

    // Stock counters start empty after reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < N_PROD; i++) begin
                stock_q[i] <= '0;
            end
            sold_out_q <= 1'b0;
        end else begin
            stock_q    <= stock_d;
            sold_out_q <= sold_out_d;
        end
    end

    assign sold_out = sold_out_q;
`else
    logic unused_stock;
    assign unused_stock = ^{stock_ld, stock_idx, stock_data};
    assign sold_out     = 1'b0;
`endif

    // Next-state and datapath: cancel beats sel beats coin within IDLE/COLLECT.
    always_comb begin
        state_d       = state_q;
        total_d       = total_q;
        change_amt_d  = change_amt_q;
        disp_idx_d    = disp_idx_q;
        coin_reject_d = 1'b0;
        short_funds_d = 1'b0;
`ifdef VEND_STOCK_EN
        sold_out_d    = 1'b0;
`endif
        case (state_q)
            IDLE, COLLECT: begin
                if (cancel && (state_q == COLLECT)) begin
                    change_amt_d  = total_q;
                    total_d       = '0;
                    state_d       = CHANGE;
                    coin_reject_d = coin_valid;
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (!sel_ok) begin
                        short_funds_d = 1'b1;
`ifdef VEND_STOCK_EN
                    end else if (stock_q[sel_idx] == '0) begin
                        sold_out_d = 1'b1;
`endif
                    end else if (total_q >= price_sel) begin
                        disp_idx_d   = sel_idx;
                        change_amt_d = total_q - price_sel;
                        total_d      = '0;
                        state_d      = DISPENSE;
                    end else begin
                        short_funds_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_ovf) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        total_d = coin_sum[W-1:0];
                        state_d = COLLECT;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_d = coin_valid;
                state_d       = (change_amt_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_ack) begin
                    change_amt_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs follow the state being entered so they line up with it.
        disp_d         = (state_d == DISPENSE);
        change_valid_d = (state_d == CHANGE);
        busy_d         = disp_d || change_valid_d;
    end

    // State, credit and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= IDLE;
            total_q        <= '0;
            change_amt_q   <= '0;
            disp_idx_q     <= '0;
            disp_q         <= 1'b0;
            busy_q         <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            short_funds_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            total_q        <= total_d;
            change_amt_q   <= change_amt_d;
            disp_idx_q     <= disp_idx_d;
            disp_q         <= disp_d;
            busy_q         <= busy_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            short_funds_q  <= short_funds_d;
        end
    end

    assign total        = total_q;
    assign busy         = busy_q;
    assign disp         = disp_q;
    assign disp_idx     = disp_idx_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;
    assign short_funds  = short_funds_q;

endmodule

// File: tb/tb_vend_multi_product_ctrl.sv
// tb/tb_vend_multi_product_ctrl.sv - directed self-checking bench for vend_multi_product_ctrl
module tb_vend_multi_product_ctrl;

    localparam int W       = 8;
    localparam int SW      = 2;
    localparam int STOCK_W = 4;

    logic               clk = 1'b0;
    logic               nrst;
    logic               coin_valid;
    logic [W-1:0]       coin_val;
    logic               sel_valid;
    logic [SW-1:0]      sel_idx;
    logic               cancel;
    logic               price_we;
    logic [SW-1:0]      price_idx;
    logic [W-1:0]       price_data;
    logic               stock_ld;
    logic [SW-1:0]      stock_idx;
    logic [STOCK_W-1:0] stock_data;
    logic               change_ack;
    logic [W-1:0]       total;
    logic               busy;
    logic               disp;
    logic [SW-1:0]      disp_idx;
    logic               change_valid;
    logic [W-1:0]       change_amt;
    logic               coin_reject;
    logic               short_funds;
    logic               sold_out;

    int tests = 0;
    int fails = 0;

    vend_multi_product_ctrl dut (
        .clk          (clk),
        .nrst         (nrst),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx),
        .cancel       (cancel),
        .price_we     (price_we),
        .price_idx    (price_idx),
        .price_data   (price_data),
        .stock_ld     (stock_ld),
        .stock_idx    (stock_idx),
        .stock_data   (stock_data),
        .change_ack   (change_ack),
        .total        (total),
        .busy         (busy),
        .disp         (disp),
        .disp_idx     (disp_idx),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .coin_reject  (coin_reject),
        .short_funds  (short_funds),
        .sold_out     (sold_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
        price_we   = 1'b0;
        stock_ld   = 1'b0;
        change_ack = 1'b0;
    endtask

    task automatic do_coin(input logic [W-1:0] v);
        coin_valid = 1'b1;
        coin_val   = v;
        tick();
    endtask

    task automatic do_sel(input logic [SW-1:0] i);
        sel_valid = 1'b1;
        sel_idx   = i;
        tick();
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
    endtask

    task automatic do_ack();
        change_ack = 1'b1;
        tick();
    endtask

    task automatic do_price(input logic [SW-1:0] i, input logic [W-1:0] d);
        price_we   = 1'b1;
        price_idx  = i;
        price_data = d;
        tick();
    endtask

    task automatic do_stock(input logic [SW-1:0] i, input logic [STOCK_W-1:0] d);
        stock_ld   = 1'b1;
        stock_idx  = i;
        stock_data = d;
        tick();
    endtask

    task automatic stock_all();
        for (int i = 0; i < 4; i++) begin
            do_stock(SW'(i), 4'd15);
        end
    endtask

    initial begin
        nrst = 1'b0;
        coin_valid = 1'b0; coin_val = '0; sel_valid = 1'b0; sel_idx = '0;
        cancel = 1'b0; price_we = 1'b0; price_idx = '0; price_data = '0;
        stock_ld = 1'b0; stock_idx = '0; stock_data = '0; change_ack = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_total", 32'(total), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_disp", 32'(disp), 0);
        check("rst_disp_idx", 32'(disp_idx), 0);
        check("rst_change_valid", 32'(change_valid), 0);
        check("rst_change_amt", 32'(change_amt), 0);
        check("rst_coin_reject", 32'(coin_reject), 0);
        check("rst_short_funds", 32'(short_funds), 0);
        check("rst_sold_out", 32'(sold_out), 0);
        nrst = 1'b1;
        stock_all();

        // 10+10+10, buy product 0 at 25, change 5
        do_coin(8'd10);
        check("coin1_total", 32'(total), 10);
        do_coin(8'd10);
        do_coin(8'd10);
        check("coin3_total", 32'(total), 30);
        do_sel(2'd0);
        check("buy0_disp", 32'(disp), 1);
        check("buy0_disp_idx", 32'(disp_idx), 0);
        check("buy0_busy", 32'(busy), 1);
        check("buy0_total", 32'(total), 0);
        check("buy0_cv_early", 32'(change_valid), 0);
        tick();
        check("buy0_disp_done", 32'(disp), 0);
        check("buy0_cv", 32'(change_valid), 1);
        check("buy0_amt", 32'(change_amt), 5);
        tick();
        check("buy0_cv_hold", 32'(change_valid), 1);
        check("buy0_amt_hold", 32'(change_amt), 5);
        do_coin(8'd10);
        check("change_coin_reject", 32'(coin_reject), 1);
        check("change_coin_total", 32'(total), 0);
        do_ack();
        check("ack_cv", 32'(change_valid), 0);
        check("ack_amt", 32'(change_amt), 0);
        check("ack_busy", 32'(busy), 0);
        check("ack_reject_clear", 32'(coin_reject), 0);
        do_coin(8'd5);
        check("post_ack_coin", 32'(total), 5);

        // Underfunded selection, then cancel refunds credit
        do_coin(8'd15);
        do_sel(2'd1);
        check("short_pulse", 32'(short_funds), 1);
        check("short_total", 32'(total), 20);
        check("short_disp", 32'(disp), 0);
        tick();
        check("short_clear", 32'(short_funds), 0);
        do_cancel();
        check("cancel_cv", 32'(change_valid), 1);
        check("cancel_amt", 32'(change_amt), 20);
        check("cancel_total", 32'(total), 0);
        do_ack();
        check("cancel_ack_cv", 32'(change_valid), 0);
        do_cancel();
        check("idle_cancel_cv", 32'(change_valid), 0);
        check("idle_cancel_busy", 32'(busy), 0);

        // Overflow rejection and sel-beats-coin at total 250, price 250
        do_price(2'd1, 8'd250);
        do_coin(8'd200);
        do_coin(8'd50);
        check("t250_total", 32'(total), 250);
        do_coin(8'd10);
        check("ovf_reject", 32'(coin_reject), 1);
        check("ovf_total", 32'(total), 250);
        coin_valid = 1'b1; coin_val = 8'd10;
        sel_valid = 1'b1; sel_idx = 2'd1;
        tick();
        check("combo_disp", 32'(disp), 1);
        check("combo_disp_idx", 32'(disp_idx), 1);
        check("combo_reject", 32'(coin_reject), 1);
        check("combo_amt", 32'(change_amt), 0);
        tick();
        check("combo_busy", 32'(busy), 0);
        check("combo_cv", 32'(change_valid), 0);

        // Exact fill to 255, next coin overflows
        do_coin(8'd200);
        do_coin(8'd55);
        check("t255_total", 32'(total), 255);
        check("t255_no_reject", 32'(coin_reject), 0);
        do_coin(8'd1);
        check("t255_reject", 32'(coin_reject), 1);
        check("t255_kept", 32'(total), 255);
        do_cancel();
        check("t255_refund", 32'(change_amt), 255);
        do_ack();

        // Free vend from idle, no change phase
        do_price(2'd2, 8'd0);
        do_sel(2'd2);
        check("free_disp", 32'(disp), 1);
        check("free_disp_idx", 32'(disp_idx), 2);
        check("free_amt", 32'(change_amt), 0);
        tick();
        check("free_busy", 32'(busy), 0);
        check("free_cv", 32'(change_valid), 0);

        // Price write during CHANGE is ignored
        do_coin(8'd30);
        do_cancel();
        do_price(2'd0, 8'd7);
        do_ack();
        do_coin(8'd30);
        do_sel(2'd0);
        tick();
        check("price_ignored_amt", 32'(change_amt), 5);
        do_ack();

        // Stock: one unit of product 3, two funded selections
        do_stock(2'd3, 4'd1);
        do_coin(8'd30);
        do_sel(2'd3);
        check("stock1_disp", 32'(disp), 1);
        check("stock1_idx", 32'(disp_idx), 3);
        tick();
        check("stock1_amt", 32'(change_amt), 5);
        do_ack();
        do_coin(8'd30);
        do_sel(2'd3);
`ifdef VEND_STOCK_EN
        check("stock2_sold_out", 32'(sold_out), 1);
        check("stock2_disp", 32'(disp), 0);
        check("stock2_total", 32'(total), 30);
        tick();
        check("stock2_sold_clear", 32'(sold_out), 0);
        do_cancel();
        check("stock2_refund", 32'(change_amt), 30);
        do_ack();
`else
        check("stock2_sold_out", 32'(sold_out), 0);
        check("stock2_disp", 32'(disp), 1);
        tick();
        check("stock2_amt", 32'(change_amt), 5);
        do_ack();
`endif

        // Asynchronous reset while change is pending
        do_coin(8'd40);
        do_cancel();
        check("pre_rst_cv", 32'(change_valid), 1);
        nrst = 1'b0;
        #2;
        check("arst_cv", 32'(change_valid), 0);
        check("arst_amt", 32'(change_amt), 0);
        check("arst_total", 32'(total), 0);
        check("arst_busy", 32'(busy), 0);
        tick();
        nrst = 1'b1;
        stock_all();
        do_sel(2'd2);
        check("arst_price2_short", 32'(short_funds), 1);
        check("arst_price2_disp", 32'(disp), 0);
        do_coin(8'd30);
        do_sel(2'd1);
        check("arst_price1_disp", 32'(disp), 1);
        tick();
        check("arst_price1_amt", 32'(change_amt), 5);
        do_ack();
        check("final_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
